// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Shared counter width, counter type, 640x480@60 default timing
//            constants and helpers that derive the per-axis totals.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int CTR_W   = 12;
  localparam int CTR_MAX = (1 << CTR_W) - 1;

  typedef logic [CTR_W-1:0] ctr_t;

  // 640x480 @ 60 Hz, 25.175 MHz nominal pixel rate
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(int active, int fp, int sync, int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_ctr.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_ctr
// Purpose  : One raster axis (horizontal or vertical). Counts 0..TOTAL-1 when
//            stepped, flags the terminal count and produces a registered sync
//            derived from the next-state count so it lines up with count.
// Ports    : clk, rst_n (async, active-low), step  - inputs
//            count       - current position (flop)
//            wrap        - count is at TOTAL-1 (combinational, unqualified)
//            sync        - sync level for the current count (flop)
//            active_next - next-state count lies in the active region
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = DEF_H_ACTIVE,
  parameter int FP       = DEF_H_FP,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BP       = DEF_H_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output ctr_t count,
  output logic wrap,
  output logic sync,
  output logic active_next
);

  localparam int   TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam ctr_t LAST       = ctr_t'(TOTAL - 1);
  localparam ctr_t SYNC_FIRST = ctr_t'(ACTIVE + FP);
  localparam ctr_t SYNC_LAST  = ctr_t'(ACTIVE + FP + SYNC - 1);
  localparam ctr_t ACTIVE_END = ctr_t'(ACTIVE);

  ctr_t count_next;
  logic in_sync;
  logic sync_next;

  assign wrap = (count == LAST);

  always_comb begin
    count_next = count;
    if (step) begin
      count_next = wrap ? '0 : count + ctr_t'(1);
    end
  end

  // Decoding the next-state count keeps sync/active aligned with the count
  // value that will be presented alongside them after the edge.
  assign in_sync     = (count_next >= SYNC_FIRST) && (count_next <= SYNC_LAST);
  assign sync_next   = in_sync ? SYNC_POL : ~SYNC_POL;
  assign active_next = (count_next < ACTIVE_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sync  <= ~SYNC_POL;
    end else begin
      count <= count_next;
      sync  <= sync_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Raster timing generator (default 640x480 @ 60 Hz). Produces the
//            pixel/line counters plus h_sync, v_sync, video_on and a
//            one-cycle frame_start pulse, all as flop outputs aligned with
//            the counters. h_sync/v_sync come straight from flops because
//            v_sync is used as a clock downstream.
// Ports    : rfr_clk     - pixel/system clock
//            reset_n     - asynchronous active-low reset
//            pix_en      - pixel-rate enable, counters advance only when 1
//            pixel_cnt   - horizontal position 0..H_TOTAL-1
//            line_cnt    - vertical position 0..V_TOTAL-1
//            h_sync      - horizontal sync, SYNC_POL-active
//            v_sync      - vertical sync, SYNC_POL-active
//            video_on    - inside the visible region
//            frame_start - one enabled cycle on wrap to (0,0)
// Options  : VGA_SYNC_DELAY_EN - adds one pix_en-qualified register stage on
//            h_sync, v_sync and video_on to match a registered colour path.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0
) (
  input  logic rfr_clk,
  input  logic reset_n,
  input  logic pix_en,
  output ctr_t pixel_cnt,
  output ctr_t line_cnt,
  output logic h_sync,
  output logic v_sync,
  output logic video_on,
  output logic frame_start
);

  localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam bit SYNC_ACT = (SYNC_POL != 0);

  if ((H_TOTAL > CTR_MAX) || (V_TOTAL > CTR_MAX)) begin : g_total_range_err
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
  end

  logic h_wrap;
  logic v_wrap;
  logic h_sync_q;
  logic v_sync_q;
  logic h_act_next;
  logic v_act_next;
  logic v_step;
  logic video_on_q;
  logic frame_start_q;

  // The line counter only moves on the enabled edge that wraps the pixel
  // counter, so v_sync can only change together with pixel_cnt -> 0.
  assign v_step = pix_en & h_wrap;

  vga_axis_ctr #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_ACT)
  ) u_h_ctr (
    .clk         (rfr_clk),
    .rst_n       (reset_n),
    .step        (pix_en),
    .count       (pixel_cnt),
    .wrap        (h_wrap),
    .sync        (h_sync_q),
    .active_next (h_act_next)
  );

  vga_axis_ctr #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_ACT)
  ) u_v_ctr (
    .clk         (rfr_clk),
    .rst_n       (reset_n),
    .step        (v_step),
    .count       (line_cnt),
    .wrap        (v_wrap),
    .sync        (v_sync_q),
    .active_next (v_act_next)
  );

  // frame_start is computed from the current terminal counts so it is set in
  // the same cycle the counters read (0,0); a held cycle clears it.
  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      video_on_q    <= h_act_next & v_act_next;
      frame_start_q <= pix_en & h_wrap & v_wrap;
    end
  end

  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_DELAY_EN
  logic h_sync_d;
  logic v_sync_d;
  logic video_on_d;

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_sync_d   <= ~SYNC_ACT;
      v_sync_d   <= ~SYNC_ACT;
      video_on_d <= 1'b0;
    end else if (pix_en) begin
      h_sync_d   <= h_sync_q;
      v_sync_d   <= v_sync_q;
      video_on_d <= video_on_q;
    end
  end

  assign h_sync   = h_sync_d;
  assign v_sync   = v_sync_d;
  assign video_on = video_on_d;
`else
  assign h_sync   = h_sync_q;
  assign v_sync   = v_sync_q;
  assign video_on = video_on_q;
`endif

endmodule
`default_nettype wire
